// File: rtl/snake_tile_map.sv
// Snake playfield tile store: host-written 20x15 grid of 4-bit tile codes, a
// power-on/on-demand clear sweep, and a 2-cycle pixel fetch feeding the renderer.
module snake_tile_map #(
  parameter int COLS = 20,
  parameter int ROWS = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        VGA_BLANK_n,
  output logic [3:0]  tile_code,
  output logic [9:0]  sprite_addr,
  output logic        pix_valid,
  output logic        busy
);

  localparam int CELLS = COLS * ROWS;
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [4:0]       COLS_L   = 5'(COLS);
  localparam logic [4:0]       ROWS_L   = 5'(ROWS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  function automatic logic [IDX_W-1:0] cell_index(input logic [4:0] r, input logic [4:0] c);
    logic [31:0] t;
    t = 32'(r) * 32'(COLS) + 32'(c);
    return t[IDX_W-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic [4:0]       col_q;
  logic [3:0]       row_q;
  logic [7:0]       readdata_q;
  logic [7:0]       rd_mux;

  logic             host_wr;
  logic             start_clr;
  logic             host_tile;
  logic [IDX_W-1:0] host_idx;

  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [3:0]       ram_wdata;
  logic [3:0]       mem [CELLS];

  logic [4:0]       pix_col, pix_row;
  logic             pix_in_grid;

  logic [IDX_W-1:0] rd_idx_p1;
  logic             in_grid_p1, vld_p1;
  logic [4:0]       x_p1, y_p1;
  logic [3:0]       tile_p2;
  logic             in_grid_p2, vld_p2;
  logic [9:0]       addr_p2;

  logic             unused_bits;
  assign unused_bits = ^{writedata[7:5], hcount[0]};

  assign host_wr   = chipselect && write;
  assign start_clr = host_wr && (address == 3'd3) && writedata[0];
  assign busy      = (state_q == S_CLEAR);
  assign host_idx  = cell_index({1'b0, row_q}, col_q);
  assign host_tile = host_wr && (address == 3'd2) && !busy &&
                     (col_q < COLS_L) && ({1'b0, row_q} < ROWS_L);

  // Clear engine
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start_clr) begin
          state_d   = S_CLEAR;
          clr_idx_d = '0;
        end
      end
      S_CLEAR: begin
        if (clr_idx_q == LAST_IDX) begin
          state_d   = S_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Host register file
  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux = {3'b000, col_q};
      3'd1:    rd_mux = {4'b0000, row_q};
      3'd3:    rd_mux = {7'b0, busy};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q      <= '0;
      row_q      <= '0;
      readdata_q <= '0;
    end else begin
      if (host_wr && address == 3'd0) col_q <= writedata[4:0];
      if (host_wr && address == 3'd1) row_q <= writedata[3:0];
      if (chipselect && read)         readdata_q <= rd_mux;
    end
  end

  assign readdata = readdata_q;

  // The clear engine owns the write port while sweeping, so host tile writes lose.
  assign ram_we    = busy || host_tile;
  assign ram_waddr = busy ? clr_idx_q : host_idx;
  assign ram_wdata = busy ? 4'd0 : writedata[3:0];

  assign pix_col     = hcount[10:6];
  assign pix_row     = vcount[9:5];
  assign pix_in_grid = (pix_col < COLS_L) && (pix_row < ROWS_L);

  // Stage 1: decode pixel position into cell, in-tile offset and read index
  always_ff @(posedge clk) begin
    if (reset) begin
      in_grid_p1 <= 1'b0;
      vld_p1     <= 1'b0;
      rd_idx_p1  <= '0;
    end else begin
      in_grid_p1 <= pix_in_grid;
      vld_p1     <= VGA_BLANK_n;
      rd_idx_p1  <= pix_in_grid ? cell_index(pix_row, pix_col) : '0;
    end
  end

  always_ff @(posedge clk) begin
    x_p1 <= hcount[5:1];
    y_p1 <= vcount[4:0];
  end

  // Stage 2: RAM read (old data on same-cell collision) and output alignment
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    tile_p2 <= mem[rd_idx_p1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_grid_p2 <= 1'b0;
      vld_p2     <= 1'b0;
      addr_p2    <= '0;
    end else begin
      in_grid_p2 <= in_grid_p1;
      vld_p2     <= vld_p1;
      addr_p2    <= {y_p1, x_p1};
    end
  end

  assign tile_code   = in_grid_p2 ? tile_p2 : 4'd0;
  assign sprite_addr = addr_p2;
  assign pix_valid   = vld_p2 && in_grid_p2;

endmodule
